fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Consumer end of the program-counter interface: accepts the PC value each cycle, issues reads to the synchronous instruction ROM, and buffers returned instructions with their PC tags in a small FIFO for decode.
- Provides backpressure (PcStall) to the program counter and a valid/ready handshake to decode.
- Flush input discards all buffered and in-flight fetches on a taken branch.

Parameters:
- L, 10, PC / ROM address width; equals the ROM address width A.
- W, 9, instruction width.
- D, 4, FIFO depth in entries; power of two, minimum 2.

Ports:
- Clk, input, 1, clock; all state changes on the rising edge.
- Reset_n, input, 1, asynchronous active-low reset.
- ProgCtr, input, L, current PC value from the program counter.
- PcValid, input, 1, ProgCtr holds a fetch request this cycle.
- PcStall, output, 1, request not accepted; the PC must hold its value (drives the PC's hold/Start input).
- RomAddr, output, L, ROM read address.
- RomRe, output, 1, ROM read enable.
- RomData, input, W, ROM read data; valid exactly 1 cycle after RomRe.
- InstOut, output, W, head-of-queue instruction.
- InstPc, output, L, PC tag of InstOut.
- InstValid, output, 1, queue head is valid.
- InstReady, input, 1, decode consumes the head this cycle.
- Flush, input, 1, discard all queued and in-flight fetches.

Behaviour:
- Async reset (Reset_n=0):
  - count, read pointer, write pointer and inflight flag all clear to 0.
  - InstValid=0, RomRe=0, PcStall=0, RomAddr=0, InstOut=0, InstPc=0.
  - Reset applies immediately, mid-fetch included; any in-flight ROM data is dropped.
- Occupancy: occ = count + inflight (0..D).
  - count width is clog2(D+1); no wrap past D.
  - Pointers are clog2(D) bits and wrap modulo D.
- Issue (combinational):
  - accept = PcValid && !Flush && (occ < D, or occ == D with a pop this cycle).
  - RomRe = accept; RomAddr = ProgCtr.
  - PcStall = PcValid && !accept.
- In-flight: on accept, register inflight=1 and capture ProgCtr as the pending tag. Otherwise inflight=0 next cycle.
- Return (cycle after issue, inflight=1 and !Flush): write {pending tag, RomData} at the write pointer, then advance it.
- Pop: when InstValid && InstReady && !Flush, advance the read pointer.
- Count update:
  - Push and pop in the same cycle: count unchanged.
  - Push only: +1.
  - Pop only: -1.
- Outputs:
  - InstValid = (count != 0); combinational from registered count.
  - InstOut and InstPc read the entry at the read pointer.
  - Read-to-decode latency: issue in cycle N, instruction visible with InstValid=1 in cycle N+2.
- Throughput: sustained one instruction per cycle when InstReady=1 continuously and PcValid=1.
- Flush (highest priority after reset):
  - Next cycle: count=0, pointers reset to 0, inflight=0.
  - No issue (RomRe=0) and no pop in the flush cycle; PcStall = PcValid.
  - The ROM return arriving in the flush cycle is discarded.
  - Fetch at the redirected PC resumes the cycle after Flush deasserts.
- Full: with occ==D and no pop, PcStall=1 and RomRe=0. Queue contents are unchanged and no entry is overwritten.
- Empty: InstValid=0. InstReady is ignored and count never underflows.
- InstOut/InstPc hold stable while InstValid=1 and InstReady=0.

Decomposition:
- Shared package (fetch_pkg) holds:
  - Constants PC_W=10, INST_W=9, FQ_DEPTH=4.
  - Typedef fq_entry_t = struct packed {logic [PC_W-1:0] pc; logic [INST_W-1:0] inst;}.
- One sub-module, fetch_fifo: parameterised synchronous FIFO of fq_entry_t with push, pop, clear, count, async active-low reset.
- Issue, in-flight tracking and flush logic stay in fetch_queue.

Test Plan:
- Reset/stream: Reset_n low then high; PcValid=1, PC stepping 0,1,2…, InstReady=1, ROM[i]=i+9'h100 → first InstValid 2 cycles after first RomRe; pairs (pc 0, inst 0x100), (1, 0x101)… one per cycle, no gaps.
- Fill: InstReady=0, PcValid=1 from PC=0 → RomRe asserted for PC 0..3 only; PcStall=1 from the 5th cycle; count=4; head holds (0, 0x100) stable.
- Full+pop: queue full; InstReady=1 for one cycle → head advances to PC 1; PC 4 accepted the same cycle; count returns to 4 two cycles later.
- Flush: 3 entries queued plus one in flight; Flush=1 for 1 cycle → next cycle InstValid=0, count=0; in-flight data never appears; PC=0x040 fetched after Flush drops, emerging as (0x040, ROM[0x40]).
- Async reset mid-operation: Reset_n pulsed low between clock edges with count=2 → InstValid=0 immediately (before next edge); RomRe=0; after release the queue refills from the current PC.
- Simultaneous push/pop at count=1 with InstReady=1 → count stays 1 and order is preserved across pointer wrap (run ≥10 entries through D=4).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch queue.
package fetch_pkg;

   localparam int unsigned PC_W     = 10;
   localparam int unsigned INST_W   = 9;
   localparam int unsigned FQ_DEPTH = 4;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear, count and async active-low reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter type          T     = fq_entry_t,
   parameter int unsigned  DEPTH = FQ_DEPTH,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  T              data_i,
   input  logic          pop_i,
   input  logic          clear_i,
   output T              data_o,
   output logic [CW-1:0] count_o
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   T              mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   // Next pointers and occupancy; clear overrides push and pop
   always_comb begin
      pop_ok  = pop_i && (count_q != '0);
      push_ok = push_i && (count_q != FULL);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clear_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + PW'(1);
         if (pop_ok)  rptr_d = rptr_q + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State and storage; reset also zeroes storage so the head reads as zero
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         mem_q   <= '{default: '0};
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (push_ok && !clear_i) mem_q[wptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: issues PC reads to a 1-cycle synchronous ROM, tracks the single
// in-flight read, and buffers {pc, inst} pairs for decode with flush support.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned L = PC_W,
   parameter int unsigned W = INST_W,
   parameter int unsigned D = FQ_DEPTH
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic [L-1:0] ProgCtr,
   input  logic         PcValid,
   output logic         PcStall,
   output logic [L-1:0] RomAddr,
   output logic         RomRe,
   input  logic [W-1:0] RomData,
   output logic [W-1:0] InstOut,
   output logic [L-1:0] InstPc,
   output logic         InstValid,
   input  logic         InstReady,
   input  logic         Flush
);

   localparam int unsigned CW       = $clog2(D + 1);
   localparam logic [CW:0] OCC_FULL = (CW + 1)'(D);

   typedef struct packed {
      logic [L-1:0] pc;
      logic [W-1:0] inst;
   } entry_t;

   logic          inflight_q, inflight_d;
   logic [L-1:0]  tag_q, tag_d;
   logic [CW-1:0] count;
   logic [CW:0]   occ;
   logic          pop, push, accept;
   entry_t        wr_entry, head;

   // Issue, pop and push decisions. Reset gates only the outputs so the
   // register inputs never depend on the asynchronous reset net.
   always_comb begin
      occ        = {1'b0, count} + {{CW{1'b0}}, inflight_q};
      pop        = (count != '0) && InstReady && !Flush;
      push       = inflight_q && !Flush;
      accept     = PcValid && !Flush && ((occ < OCC_FULL) || ((occ == OCC_FULL) && pop));
      inflight_d = accept;
      tag_d      = accept ? ProgCtr : tag_q;
      wr_entry   = '{pc: tag_q, inst: RomData};
      RomRe      = Reset_n && accept;
      RomAddr    = Reset_n ? ProgCtr : '0;
      PcStall    = Reset_n && PcValid && !accept;
   end

   // In-flight read tracking; a flush drops the pending read via accept=0
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         inflight_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
      end
   end

   fetch_fifo #(
      .T     (entry_t),
      .DEPTH (D)
   ) u_fifo (
      .clk_i   (Clk),
      .rst_ni  (Reset_n),
      .push_i  (push),
      .data_i  (wr_entry),
      .pop_i   (pop),
      .clear_i (Flush),
      .data_o  (head),
      .count_o (count)
   );

   assign InstValid = (count != '0);
   assign InstOut   = head.inst;
   assign InstPc    = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run, all
// compared against a queue-level reference model of the fetch pipeline.
module tb_fetch_queue;

   localparam int unsigned L = 10;
   localparam int unsigned W = 9;
   localparam int unsigned D = 4;

   logic         Clk = 1'b0;
   logic         Reset_n;
   logic [L-1:0] ProgCtr;
   logic         PcValid;
   logic         PcStall;
   logic [L-1:0] RomAddr;
   logic         RomRe;
   logic [W-1:0] RomData = '0;
   logic [W-1:0] InstOut;
   logic [L-1:0] InstPc;
   logic         InstValid;
   logic         InstReady;
   logic         Flush;

   int checks = 0;
   int errors = 0;

   fetch_queue #(.L(L), .W(W), .D(D)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .ProgCtr   (ProgCtr),
      .PcValid   (PcValid),
      .PcStall   (PcStall),
      .RomAddr   (RomAddr),
      .RomRe     (RomRe),
      .RomData   (RomData),
      .InstOut   (InstOut),
      .InstPc    (InstPc),
      .InstValid (InstValid),
      .InstReady (InstReady),
      .Flush     (Flush)
   );

   always #5 Clk = ~Clk;

   function automatic logic [W-1:0] rom_word(input logic [L-1:0] a);
      return W'(a) + 9'h100;
   endfunction

   // Synchronous ROM: data one cycle after the read enable
   always @(posedge Clk) if (RomRe) RomData <= rom_word(RomAddr);

   // Reference model: queue of returned entries plus one pending read
   typedef struct packed {
      logic [L-1:0] pc;
      logic [W-1:0] inst;
   } ent_t;

   ent_t         mq[$];
   bit           m_busy = 1'b0;
   logic [L-1:0] m_tag  = '0;

   function automatic bit m_pop();
      return Reset_n && (mq.size() != 0) && InstReady && !Flush;
   endfunction

   function automatic bit m_accept();
      int unsigned occ;
      occ = mq.size() + (m_busy ? 1 : 0);
      return Reset_n && PcValid && !Flush && ((occ < D) || ((occ == D) && m_pop()));
   endfunction

   // Model update at each rising edge; asynchronous reset empties everything
   always @(posedge Clk or negedge Reset_n) begin
      bit p, a;
      if (!Reset_n) begin
         mq.delete();
         m_busy = 1'b0;
         m_tag  = '0;
      end else if (Flush) begin
         mq.delete();
         m_busy = 1'b0;
      end else begin
         p = m_pop();
         a = m_accept();
         if (p) void'(mq.pop_front());
         if (m_busy) mq.push_back('{pc: m_tag, inst: rom_word(m_tag)});
         m_busy = a;
         if (a) m_tag = ProgCtr;
      end
   end

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic apply_reset();
      @(negedge Clk);
      Reset_n   = 1'b0;
      PcValid   = 1'b0;
      InstReady = 1'b0;
      Flush     = 1'b0;
      ProgCtr   = '0;
      tick();
      Reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge Clk);
      Reset_n   = 1'b0;
      PcValid   = 1'b1;
      InstReady = 1'b1;
      Flush     = 1'b0;
      ProgCtr   = 10'h2a5;
      #1;
      checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", InstValid); end
      checks++; if (RomRe !== 1'b0) begin errors++; $display("FAIL reset_romre got %b exp 0", RomRe); end
      checks++; if (PcStall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", PcStall); end
      checks++; if (RomAddr !== '0) begin errors++; $display("FAIL reset_romaddr got %h exp 0", RomAddr); end
      checks++; if (InstOut !== '0) begin errors++; $display("FAIL reset_instout got %h exp 0", InstOut); end
      checks++; if (InstPc !== '0) begin errors++; $display("FAIL reset_instpc got %h exp 0", InstPc); end
      tick();
      Reset_n = 1'b1;
      PcValid = 1'b0;
   endtask

   task automatic test_stream();
      logic [L-1:0] pc;
      int first_re, first_v;
      bit adv;
      apply_reset();
      pc = '0; PcValid = 1'b1; InstReady = 1'b1;
      first_re = -1; first_v = -1;
      for (int c = 0; c < 20; c++) begin
         ProgCtr = pc;
         #1;
         if (RomRe && first_re < 0) first_re = c;
         if (InstValid && first_v < 0) first_v = c;
         checks++; if (RomRe !== m_accept()) begin errors++; $display("FAIL stream_romre c=%0d got %b exp %b", c, RomRe, m_accept()); end
         checks++; if (InstValid !== (mq.size() != 0)) begin errors++; $display("FAIL stream_valid c=%0d got %b exp %b", c, InstValid, mq.size() != 0); end
         if (c >= 2) begin
            checks++; if (InstValid !== 1'b1) begin errors++; $display("FAIL stream_gap c=%0d got %b exp 1", c, InstValid); end
            checks++; if (InstPc !== L'(c - 2)) begin errors++; $display("FAIL stream_pc c=%0d got %h exp %h", c, InstPc, L'(c - 2)); end
            checks++; if (InstOut !== rom_word(L'(c - 2))) begin errors++; $display("FAIL stream_inst c=%0d got %h exp %h", c, InstOut, rom_word(L'(c - 2))); end
         end
         adv = PcValid && !PcStall;
         tick();
         if (adv) pc++;
      end
      checks++; if (first_re !== 0) begin errors++; $display("FAIL stream_first_re got %0d exp 0", first_re); end
      checks++; if (first_v - first_re !== 2) begin errors++; $display("FAIL stream_latency got %0d exp 2", first_v - first_re); end
   endtask

   task automatic test_fill_and_pop();
      logic [L-1:0] pc;
      bit adv;
      apply_reset();
      pc = '0; PcValid = 1'b1; InstReady = 1'b0;
      for (int c = 0; c < 8; c++) begin
         ProgCtr = pc;
         #1;
         checks++; if (RomRe !== (c < 4)) begin errors++; $display("FAIL fill_romre c=%0d got %b exp %b", c, RomRe, c < 4); end
         checks++; if (PcStall !== (c >= 4)) begin errors++; $display("FAIL fill_stall c=%0d got %b exp %b", c, PcStall, c >= 4); end
         if (c >= 2) begin
            checks++; if ({InstValid, InstPc, InstOut} !== {1'b1, 10'h000, 9'h100}) begin
               errors++; $display("FAIL fill_head c=%0d got v=%b pc=%h inst=%h exp 1/000/100", c, InstValid, InstPc, InstOut); end
         end
         adv = PcValid && !PcStall;
         tick();
         if (adv) pc++;
      end
      // full queue: one pop lets PC 4 in on the same cycle
      InstReady = 1'b1;
      ProgCtr   = pc;
      #1;
      checks++; if ({RomRe, PcStall, RomAddr} !== {1'b1, 1'b0, 10'd4}) begin
         errors++; $display("FAIL fullpop_issue got re=%b st=%b addr=%h exp 1/0/004", RomRe, PcStall, RomAddr); end
      adv = PcValid && !PcStall;
      tick();
      if (adv) pc++;
      InstReady = 1'b0;
      ProgCtr   = pc;
      #1;
      checks++; if ({InstPc, InstOut} !== {10'd1, 9'h101}) begin
         errors++; $display("FAIL fullpop_head got pc=%h inst=%h exp 001/101", InstPc, InstOut); end
      checks++; if (PcStall !== 1'b1) begin errors++; $display("FAIL fullpop_stall1 got %b exp 1", PcStall); end
      tick();
      #1;
      checks++; if ({RomRe, PcStall} !== 2'b01) begin errors++; $display("FAIL fullpop_stall2 got re=%b st=%b exp 0/1", RomRe, PcStall); end
      // drain: exactly four entries, PCs 1..4, in order
      PcValid = 1'b0; InstReady = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         #1;
         if (k <= 4) begin
            checks++; if ({InstValid, InstPc, InstOut} !== {1'b1, L'(k), rom_word(L'(k))}) begin
               errors++; $display("FAIL drain k=%0d got v=%b pc=%h inst=%h", k, InstValid, InstPc, InstOut); end
         end else begin
            checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", InstValid); end
         end
         tick();
      end
   endtask

   task automatic test_flush();
      logic [L-1:0] pc;
      bit adv, saw3, seen;
      logic [L-1:0] first_pc;
      logic [W-1:0] first_inst;
      apply_reset();
      pc = '0; PcValid = 1'b1; InstReady = 1'b0;
      for (int c = 0; c < 4; c++) begin
         ProgCtr = pc;
         #1;
         adv = PcValid && !PcStall;
         tick();
         if (adv) pc++;
      end
      // three queued, PC 3 in flight
      Flush   = 1'b1;
      ProgCtr = pc;
      #1;
      checks++; if ({RomRe, PcStall, InstValid} !== 3'b011) begin
         errors++; $display("FAIL flush_cycle got re=%b st=%b v=%b exp 0/1/1", RomRe, PcStall, InstValid); end
      tick();
      Flush = 1'b0; pc = 10'h040; ProgCtr = pc; InstReady = 1'b1;
      #1;
      checks++; if ({InstValid, RomRe, RomAddr} !== {1'b0, 1'b1, 10'h040}) begin
         errors++; $display("FAIL flush_after got v=%b re=%b addr=%h exp 0/1/040", InstValid, RomRe, RomAddr); end
      saw3 = 1'b0; seen = 1'b0; first_pc = '0; first_inst = '0;
      for (int c = 0; c < 6; c++) begin
         ProgCtr = pc;
         #1;
         if (InstValid && InstPc == 10'd3) saw3 = 1'b1;
         if (InstValid && !seen) begin seen = 1'b1; first_pc = InstPc; first_inst = InstOut; end
         checks++; if (InstValid !== (mq.size() != 0)) begin errors++; $display("FAIL flush_valid c=%0d got %b exp %b", c, InstValid, mq.size() != 0); end
         adv = PcValid && !PcStall;
         tick();
         if (adv) pc++;
      end
      checks++; if (saw3 !== 1'b0) begin errors++; $display("FAIL flush_dropped got %b exp 0", saw3); end
      checks++; if ({seen, first_pc, first_inst} !== {1'b1, 10'h040, 9'h140}) begin
         errors++; $display("FAIL flush_redirect got seen=%b pc=%h inst=%h exp 1/040/140", seen, first_pc, first_inst); end
   endtask

   task automatic test_async_reset();
      logic [L-1:0] pc;
      bit adv;
      apply_reset();
      pc = '0; PcValid = 1'b1; InstReady = 1'b0;
      for (int c = 0; c < 3; c++) begin
         ProgCtr = pc;
         #1;
         adv = PcValid && !PcStall;
         tick();
         if (adv) pc++;
      end
      ProgCtr = pc;
      #1;
      checks++; if (InstValid !== 1'b1) begin errors++; $display("FAIL areset_pre got %b exp 1", InstValid); end
      Reset_n = 1'b0;
      #1;
      checks++; if ({InstValid, RomRe, PcStall} !== 3'b000) begin
         errors++; $display("FAIL areset_during got v=%b re=%b st=%b exp 0/0/0", InstValid, RomRe, PcStall); end
      Reset_n = 1'b1;
      InstReady = 1'b1;
      #1;
      adv = PcValid && !PcStall;
      tick();
      if (adv) pc++;
      for (int c = 0; c < 4; c++) begin
         ProgCtr = pc;
         #1;
         if (c == 1) begin
            checks++; if ({InstValid, InstPc, InstOut} !== {1'b1, 10'd3, rom_word(10'd3)}) begin
               errors++; $display("FAIL areset_refill got v=%b pc=%h inst=%h exp 1/003/103", InstValid, InstPc, InstOut); end
         end
         checks++; if (InstValid !== (mq.size() != 0)) begin errors++; $display("FAIL areset_valid c=%0d got %b exp %b", c, InstValid, mq.size() != 0); end
         adv = PcValid && !PcStall;
         tick();
         if (adv) pc++;
      end
   endtask

   task automatic test_back_to_back_wrap();
      logic [L-1:0] pc;
      bit adv;
      apply_reset();
      pc = 10'h3f8; PcValid = 1'b1; InstReady = 1'b1;
      for (int c = 0; c < 16; c++) begin
         ProgCtr = pc;
         #1;
         checks++; if (PcStall !== 1'b0) begin errors++; $display("FAIL b2b_stall c=%0d got %b exp 0", c, PcStall); end
         if (c >= 2) begin
            checks++; if ({InstValid, InstPc, InstOut} !== {1'b1, L'(10'h3f8 + c - 2), rom_word(L'(10'h3f8 + c - 2))}) begin
               errors++; $display("FAIL b2b_order c=%0d got v=%b pc=%h inst=%h", c, InstValid, InstPc, InstOut); end
         end
         adv = PcValid && !PcStall;
         tick();
         if (adv) pc++;
      end
   endtask

   task automatic test_random();
      logic [L-1:0] pc;
      bit adv;
      apply_reset();
      pc = L'($urandom);
      for (int c = 0; c < 400; c++) begin
         PcValid   = ($urandom_range(0, 3) != 0);
         InstReady = ($urandom_range(0, 1) != 0);
         Flush     = ($urandom_range(0, 19) == 0);
         ProgCtr   = pc;
         #1;
         checks++; if (RomRe !== m_accept()) begin errors++; $display("FAIL rand_romre c=%0d got %b exp %b", c, RomRe, m_accept()); end
         checks++; if (PcStall !== (PcValid && !m_accept())) begin errors++; $display("FAIL rand_stall c=%0d got %b exp %b", c, PcStall, PcValid && !m_accept()); end
         checks++; if (InstValid !== (mq.size() != 0)) begin errors++; $display("FAIL rand_valid c=%0d got %b exp %b", c, InstValid, mq.size() != 0); end
         if (mq.size() != 0) begin
            checks++; if ({InstPc, InstOut} !== {mq[0].pc, mq[0].inst}) begin
               errors++; $display("FAIL rand_head c=%0d got %h/%h exp %h/%h", c, InstPc, InstOut, mq[0].pc, mq[0].inst); end
         end
         adv = PcValid && !PcStall;
         tick();
         if (Flush) pc = L'($urandom);
         else if (adv) pc++;
      end
      Flush = 1'b0;
   endtask

   initial begin
      Reset_n = 1'b0; PcValid = 1'b0; InstReady = 1'b0; Flush = 1'b0; ProgCtr = '0;
      repeat (2) @(negedge Clk);
      test_reset();
      test_stream();
      test_fill_and_pop();
      test_flush();
      test_async_reset();
      test_back_to_back_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog timeout");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
